// File: rtl/rom_banked_ctrl_if.sv
// -----------------------------------------------------------------------------
// rom_banked_ctrl_if
// Bus bundle between the CPU-side bus decoder and the banked boot/BASIC ROM.
//
// Signals:
//   address   word address within the current bank        (master -> slave)
//   ce        chip enable from the bus decoder, active high (master -> slave)
//   rd_en     read strobe, active high                      (master -> slave)
//   bank_we   load bank_sel into the bank register         (master -> slave)
//   bank_sel  new bank number                               (master -> slave)
//   q         registered read data, held between accesses  (slave -> master)
//   valid     one-cycle pulse, q is new in this cycle      (slave -> master)
//   busy      an access is in progress                     (slave -> master)
//   wait_n    CPU WAIT, active low, low while busy         (slave -> master)
// -----------------------------------------------------------------------------
interface rom_banked_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int BANK_BITS  = 1
) ();

    logic [ADDR_WIDTH-1:0] address;
    logic                  ce;
    logic                  rd_en;
    logic                  bank_we;
    logic [BANK_BITS-1:0]  bank_sel;
    logic [DATA_WIDTH-1:0] q;
    logic                  valid;
    logic                  busy;
    logic                  wait_n;

    modport master (
        output address, ce, rd_en, bank_we, bank_sel,
        input  q, valid, busy, wait_n
    );

    modport slave (
        input  address, ce, rd_en, bank_we, bank_sel,
        output q, valid, busy, wait_n
    );

endinterface

// File: rtl/rom_banked_ctrl.sv
// -----------------------------------------------------------------------------
// rom_banked_ctrl
// Bank-switched boot/BASIC ROM with a Z80-style read handshake. The image lives
// in an inferred block-RAM array (registered read, no reset on the array),
// preloaded with FILL_VALUE.
//
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      rom_banked_ctrl_if.slave (address/ce/rd_en/bank_we/bank_sel in,
//            q/valid/busy/wait_n out)
//
// Access sequence (start sampled at edge k, W = WAIT_CYCLES):
//   IDLE -> READ (1 cycle, array read) -> WAIT (W cycles, skipped if W==0)
//   -> DONE (1 cycle) -> IDLE.
//   busy/wait_n are asserted from the cycle after edge k; q/valid/busy/wait_n
//   are all registered, so the edge that leaves DONE loads q, pulses valid and
//   releases busy/wait_n: valid is high in the cycle after edge k+2+W and
//   wait_n is low for W+2 cycles.
// -----------------------------------------------------------------------------
module rom_banked_ctrl #(
    parameter int    ADDR_WIDTH  = 15,
    parameter int    DATA_WIDTH  = 8,
    parameter int    BANK_BITS   = 1,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = "",
    parameter        FILL_VALUE  = 8'hFF
) (
    input  logic               clock,
    input  logic               reset_n,
    rom_banked_ctrl_if.slave   bus
);

    localparam int FULL_WIDTH = BANK_BITS + ADDR_WIDTH;
    localparam int DEPTH      = 1 << FULL_WIDTH;

    // FILL_VALUE is extended or truncated to the data word.
    localparam logic [DATA_WIDTH-1:0] FILL_WORD = DATA_WIDTH'(FILL_VALUE);
    localparam bit                    HAS_WAIT  = (WAIT_CYCLES > 0);
    // The counter is loaded with W-1 so that WAIT lasts exactly W cycles.
    localparam logic [3:0]            WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    req_s;
    logic                    start_s;
    logic                    req_prev_r;
    logic [BANK_BITS-1:0]    bank_r;
    logic [FULL_WIDTH-1:0]   acc_addr_r;
    logic [3:0]              wait_cnt_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic [DATA_WIDTH-1:0]   q_r;
    logic                    valid_r;
    logic                    busy_r;
    logic                    wait_n_r;

    logic [DATA_WIDTH-1:0]   rom_mem_r [DEPTH];

    // Array image: fill every word.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            rom_mem_r[i] = FILL_WORD;
        end
    end

    // Only a rising edge of ce&rd_en seen in IDLE starts an access; edges
    // arriving while an access runs are dropped, not queued.
    always_comb begin
        req_s   = bus.ce & bus.rd_en;
        start_s = req_s & ~req_prev_r & (state_r == ST_IDLE);
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (HAS_WAIT) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Wait-state down-counter, loaded while the array read is in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 4'd0;
        end else if (state_r == ST_READ) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Request edge history, bank register and latched access address.
    // The address is captured with the bank value from before any bank_we in
    // the same cycle, and later bank writes cannot disturb a running access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_prev_r <= 1'b0;
            bank_r     <= '0;
            acc_addr_r <= '0;
        end else begin
            req_prev_r <= req_s;
            if (bus.bank_we) begin
                bank_r <= bus.bank_sel;
            end
            if (start_s) begin
                acc_addr_r <= {bank_r, bus.address};
            end
        end
    end

    // Registered array read; no reset so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (state_r == ST_READ) begin
            rdata_r <= rom_mem_r[acc_addr_r];
        end
    end

    // Handshake outputs. Leaving DONE publishes the data and ends the access;
    // reset clears everything immediately, so an aborted access never shows.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_r      <= '0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            wait_n_r <= 1'b1;
        end else begin
            valid_r <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                q_r      <= rdata_r;
                busy_r   <= 1'b0;
                wait_n_r <= 1'b1;
            end else if (start_s) begin
                busy_r   <= 1'b1;
                wait_n_r <= 1'b0;
            end
        end
    end

    assign bus.q      = q_r;
    assign bus.valid  = valid_r;
    assign bus.busy   = busy_r;
    assign bus.wait_n = wait_n_r;

endmodule
